// File: rtl/sseg_pkg.sv
// Shared types and glyph table for the seven-segment scan monitor.
// Segment patterns are {a,b,c,d,e,f,g}, active low.
package sseg_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // An all-dark digit is never a glyph, so it is rejected before the table search.
    function automatic void seg_to_nibble(input logic [6:0] seg, output nibble_t nib, output logic hit);
        nib = '0;
        hit = 1'b0;
        if (seg != SEG_BLANK) begin
            for (int k = 0; k < 16; k++) begin
                if (seg == SEG_HEX[k]) begin
                    nib = nibble_t'(k);
                    hit = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/sseg_digit_timer.sv
// Per-digit staleness timer: saturating cycle counter cleared by a fresh capture.
// expire is high on the edge where the count reaches TIMEOUT_CYCLES.
module sseg_digit_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expire = !clear && (count == LIMIT - 1'b1);

endmodule

// File: rtl/sseg_scan_capture.sv
// Loopback monitor for a multiplexed active-low an/seg display bus.
// Recovers the four displayed hex nibbles and reports glitches, bad glyphs and ghosting.
module sseg_scan_capture import sseg_pkg::*; #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        decode_err,
    output logic        multi_sel
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_ARM = SW'(STABLE_CYCLES - 1);

    logic [3:0]    s_an;
    logic [6:0]    s_seg;
    logic [SW-1:0] stab_cnt;
    nibble_t [3:0] shadow;
    nibble_t [3:0] shadow_next;
    logic [3:0]    seen;
    logic [3:0]    seen_next;
    logic [3:0]    valid_next;
    logic [3:0]    ok_mask;
    logic [3:0]    bad_mask;
    logic [3:0]    expire;
    nibble_t       dec_nib;
    logic          dec_hit;
    logic          same;
    logic          single_sel;
    logic          multi_in;
    logic          multi_cur;
    logic          cap_fire;
    logic          frame_hit;

    // "same" compares the sample being loaded on this edge with the one already held.
    assign same       = ({an, seg} == {s_an, s_seg});
    assign single_sel = ($countones(~s_an) == 1);
    assign multi_in   = ($countones(~an) > 1);
    assign multi_cur  = ($countones(~s_an) > 1);
    assign cap_fire   = same && (stab_cnt == STAB_ARM) && single_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an     <= '0;
            s_seg    <= '0;
            stab_cnt <= '0;
        end else begin
            s_an  <= an;
            s_seg <= seg;
            if (!same) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // A digit's own timeout never beats its capture: the timer sees clear and suppresses expire.
    always_comb begin
        seg_to_nibble(s_seg, dec_nib, dec_hit);
        ok_mask     = (cap_fire && dec_hit)  ? ~s_an : 4'b0000;
        bad_mask    = (cap_fire && !dec_hit) ? ~s_an : 4'b0000;
        shadow_next = shadow;
        for (int i = 0; i < 4; i++) begin
            if (ok_mask[i]) begin
                shadow_next[i] = dec_nib;
            end
        end
        seen_next  = (seen | ok_mask) & ~bad_mask & ~expire;
        valid_next = (digit_valid | ok_mask) & ~bad_mask & ~expire;
        frame_hit  = (|ok_mask) && (seen_next == 4'b1111);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            seen        <= '0;
            digit_valid <= '0;
            value       <= '0;
            frame_done  <= 1'b0;
            decode_err  <= 1'b0;
            multi_sel   <= 1'b0;
        end else begin
            shadow      <= shadow_next;
            digit_valid <= valid_next;
            seen        <= frame_hit ? 4'b0000 : seen_next;
            if (frame_hit) begin
                value <= shadow_next;
            end
            frame_done <= frame_hit;
            decode_err <= |bad_mask;
            multi_sel  <= multi_in && !multi_cur;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_timer
        sseg_digit_timer #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_timer (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (ok_mask[i]),
            .expire (expire[i])
        );
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Self-checking bench for sseg_scan_capture: directed scenarios plus random scanning,
// compared every cycle against a run-length/age based reference model.
module tb_sseg_scan_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 50;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an    = 4'b1111;
    logic [6:0]  seg   = 7'b1111111;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        decode_err;
    logic        multi_sel;

    int vectors     = 0;
    int miscompares = 0;
    int frameCnt    = 0;
    int errCnt      = 0;
    int multiCnt    = 0;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model state
    logic [10:0] lastSamp;
    int          runLen;
    int          age [4];
    logic [3:0]  mShadow [4];
    logic [3:0]  mSeen;
    logic [3:0]  mValid;
    logic [15:0] mValue;
    logic        mFrame;
    logic        mErr;
    logic        mMulti;

    sseg_scan_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .decode_err  (decode_err),
        .multi_sel   (multi_sel)
    );

    initial forever #5 clk = ~clk;

    function automatic int zeros(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) n++;
        return n;
    endfunction

    task automatic modelReset();
        lastSamp = '0;
        runLen   = 1;
        mSeen    = '0;
        mValid   = '0;
        mValue   = '0;
        mFrame   = 1'b0;
        mErr     = 1'b0;
        mMulti   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            age[i]     = 0;
            mShadow[i] = '0;
        end
    endtask

    // One clock edge of the reference: run length of identical samples and per-digit age.
    task automatic modelStep(input logic [3:0] a, input logic [6:0] s);
        logic [10:0] samp;
        logic        prevMulti;
        logic [3:0]  expired;
        logic        capture;
        logic        hit;
        logic [3:0]  nib;
        int          d;
        samp      = {a, s};
        prevMulti = (zeros(lastSamp[10:7]) >= 2);
        if (samp == lastSamp) begin
            if (runLen < 1000) runLen++;
        end else begin
            runLen = 1;
        end
        lastSamp = samp;
        mMulti   = (zeros(a) >= 2) && !prevMulti;
        mFrame   = 1'b0;
        mErr     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expired[i] = (age[i] == TMO - 1);
            if (age[i] < TMO) age[i]++;
        end
        capture = (runLen == STABLE + 1) && (zeros(a) == 1);
        hit = 1'b0;
        nib = '0;
        d   = 0;
        if (capture) begin
            for (int i = 0; i < 4; i++) if (!a[i]) d = i;
            for (int k = 0; k < 16; k++) begin
                if (glyph[k] == s) begin
                    hit = 1'b1;
                    nib = 4'(k);
                end
            end
            if (hit) begin
                mShadow[d] = nib;
                mValid[d]  = 1'b1;
                mSeen[d]   = 1'b1;
                age[d]     = 0;
                expired[d] = 1'b0;
            end else begin
                mErr      = 1'b1;
                mValid[d] = 1'b0;
                mSeen[d]  = 1'b0;
            end
        end
        mValid = mValid & ~expired;
        mSeen  = mSeen & ~expired;
        if (capture && hit && mSeen == 4'b1111) begin
            mValue = {mShadow[3], mShadow[2], mShadow[1], mShadow[0]};
            mSeen  = '0;
            mFrame = 1'b1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Called at a falling edge; the sample is loaded on the next rising edge and held for hold further edges.
    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int hold);
        an  = a;
        seg = s;
        repeat (hold + 1) @(negedge clk);
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else        modelStep(an, seg);
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (frame_done) frameCnt++;
        if (decode_err) errCnt++;
        if (multi_sel)  multiCnt++;
    end

    initial forever begin
        @(negedge clk);
        checkOutput("value",       value,                mValue);
        checkOutput("digit_valid", {12'b0, digit_valid}, {12'b0, mValid});
        checkOutput("frame_done",  {15'b0, frame_done},  {15'b0, mFrame});
        checkOutput("decode_err",  {15'b0, decode_err},  {15'b0, mErr});
        checkOutput("multi_sel",   {15'b0, multi_sel},   {15'b0, mMulti});
    end

    initial begin
        #1_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int eBase;
        int mBase;
        logic [3:0] ra;
        logic [6:0] rs;
        int rh;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_value", value, 16'h0000);
        checkOutput("reset_valid", {12'b0, digit_valid}, 16'h0000);
        rst_n = 1'b1;

        // Full scan 1,2,3,A on digits 3..0
        base = frameCnt;
        applyStimulus(4'b0111, glyph[1], 8);
        applyStimulus(4'b1011, glyph[2], 8);
        applyStimulus(4'b1101, glyph[3], 8);
        applyStimulus(4'b1110, glyph[10], 8);
        checkOutput("scan_value",  value, 16'h123A);
        checkOutput("scan_valid",  {12'b0, digit_valid}, 16'h000F);
        checkOutput("scan_frames", 16'(frameCnt - base), 16'd1);

        // Asynchronous reset in the middle of a digit
        applyStimulus(4'b0111, glyph[5], 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midreset_value", value, 16'h0000);
        checkOutput("midreset_valid", {12'b0, digit_valid}, 16'h0000);
        checkOutput("midreset_pulses", {13'b0, frame_done, decode_err, multi_sel}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        base = frameCnt;
        applyStimulus(4'b1110, glyph[0], 8);
        applyStimulus(4'b0111, glyph[4], 8);
        applyStimulus(4'b1011, glyph[5], 8);
        checkOutput("midreset_noframe", 16'(frameCnt - base), 16'd0);
        applyStimulus(4'b1101, glyph[6], 8);
        checkOutput("midreset_frame", 16'(frameCnt - base), 16'd1);
        checkOutput("midreset_newvalue", value, 16'h4560);

        // Glitch: 3 edges of hold is too short, 4 is exactly enough
        base = frameCnt;
        applyStimulus(4'b1011, glyph[7], 3);
        applyStimulus(4'b0111, glyph[8], 8);
        applyStimulus(4'b1101, glyph[9], 8);
        applyStimulus(4'b1110, glyph[11], 8);
        checkOutput("glitch_noframe", 16'(frameCnt - base), 16'd0);
        applyStimulus(4'b1011, glyph[7], 4);
        checkOutput("glitch_frame", 16'(frameCnt - base), 16'd1);
        checkOutput("glitch_value", value, 16'h879B);

        // Bad glyph on digit 1
        eBase = errCnt;
        applyStimulus(4'b1101, 7'b1111110, 8);
        checkOutput("bad_err",   16'(errCnt - eBase), 16'd1);
        checkOutput("bad_valid", {15'b0, digit_valid[1]}, 16'd0);
        checkOutput("bad_value", value, 16'h879B);

        // Ghosting: two anodes low
        base  = frameCnt;
        eBase = errCnt;
        mBase = multiCnt;
        applyStimulus(4'b1100, glyph[8], 10);
        checkOutput("ghost_multi", 16'(multiCnt - mBase), 16'd1);
        checkOutput("ghost_err",   16'(errCnt - eBase), 16'd0);
        checkOutput("ghost_frame", 16'(frameCnt - base), 16'd0);

        // Timeout: digit 3 completes a frame, then only digits 0-2 are scanned
        applyStimulus(4'b1110, glyph[12], 4);
        applyStimulus(4'b1101, glyph[13], 4);
        applyStimulus(4'b1011, glyph[14], 4);
        applyStimulus(4'b0111, glyph[15], 4);
        base = frameCnt;
        for (int r = 0; r < 3; r++) begin
            applyStimulus(4'b1110, glyph[1], 4);
            applyStimulus(4'b1101, glyph[2], 4);
            applyStimulus(4'b1011, glyph[3], 4);
        end
        applyStimulus(4'b1111, 7'b1111111, 3);
        checkOutput("tmo_valid3_before", {15'b0, digit_valid[3]}, 16'd1);
        @(negedge clk);
        checkOutput("tmo_valid3_after", {15'b0, digit_valid[3]}, 16'd0);
        checkOutput("tmo_noframe", 16'(frameCnt - base), 16'd0);

        // Digit 3 captured on the very edge digit 0 expires
        applyStimulus(4'b1110, glyph[4], 4);
        applyStimulus(4'b1101, glyph[5], 4);
        applyStimulus(4'b1011, glyph[6], 4);
        applyStimulus(4'b1111, 7'b1111111, 34);
        applyStimulus(4'b0111, glyph[7], 8);
        checkOutput("tmo_race_noframe", 16'(frameCnt - base), 16'd0);
        checkOutput("tmo_race_valid", {12'b0, digit_valid}, 16'h000E);

        // Random scanning
        for (int n = 0; n < 250; n++) begin
            rh = $urandom_range(0, 99);
            if (rh < 70)      ra = ~(4'b0001 << $urandom_range(0, 3));
            else if (rh < 85) ra = 4'b1111;
            else              ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) rs = glyph[$urandom_range(0, 15)];
            else                           rs = 7'($urandom_range(0, 127));
            rh = ($urandom_range(0, 19) == 0) ? 60 : $urandom_range(0, 9);
            applyStimulus(ra, rs, rh);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
